// File: rtl/pmem_responder_if.sv
// Line-granular pmem handshake between the L2 cache (master) and a memory endpoint (slave).
// Request levels are held by the master until the single-cycle pmem_resp strobe.
interface pmem_responder_if;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;

  modport master (
    output pmem_read,
    output pmem_write,
    output pmem_address,
    output pmem_wdata,
    input  pmem_resp,
    input  pmem_rdata
  );

  modport slave (
    input  pmem_read,
    input  pmem_write,
    input  pmem_address,
    input  pmem_wdata,
    output pmem_resp,
    output pmem_rdata
  );
endinterface

// File: rtl/pmem_responder.sv
// Line-addressed backing store answering pmem reads/writes after LATENCY cycles.
// No backpressure: the initiator holds the request until pmem_resp; dropping it early aborts.
module pmem_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  pmem_responder_if.slave  pmem,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int         LINES    = 1 << DEPTH_LOG2;
  localparam logic [7:0] CNT_INIT = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

  logic [127:0] mem [LINES];

  state_t                state, state_nxt;
  logic [7:0]            cnt, cnt_nxt;
  logic                  req;
  logic                  accept;
  logic                  commit;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic [DEPTH_LOG2-1:0] lat_idx;
  logic                  lat_wr;
  logic [127:0]          lat_wdata;
  logic [DEPTH_LOG2-1:0] cmt_idx;
  logic                  cmt_wr;
  logic [127:0]          cmt_wdata;
  logic [127:0]          rdata_q;

  assign req     = pmem.pmem_read | pmem.pmem_write;
  assign req_idx = pmem.pmem_address[DEPTH_LOG2+3:4];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    cmt_idx   = lat_idx;
    cmt_wr    = lat_wr;
    cmt_wdata = lat_wdata;
    case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            // Single-cycle latency commits straight from the inputs being latched.
            state_nxt = RESP;
            commit    = 1'b1;
            cmt_idx   = req_idx;
            cmt_wr    = pmem.pmem_write;
            cmt_wdata = pmem.pmem_wdata;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_nxt = IDLE;
        end else if (cnt == 8'd0) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_idx   <= '0;
      lat_wr    <= 1'b0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_idx   <= req_idx;
      lat_wr    <= pmem.pmem_write;
      lat_wdata <= pmem.pmem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (commit && !cmt_wr) begin
      rdata_q <= mem[cmt_idx];
    end
  end

  // Storage has no reset; the rst_n gate keeps a request seen during reset from committing.
  always_ff @(posedge clk) begin
    if (rst_n && commit && cmt_wr) begin
      mem[cmt_idx] <= cmt_wdata;
    end
  end

  assign pmem.pmem_resp  = (state == RESP);
  assign pmem.pmem_rdata = rdata_q;
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: a LATENCY=4 instance for the main protocol and a
// LATENCY=1 instance for back-to-back acceptance.
module tb_pmem_responder;

  logic clk;
  logic rst_n;
  logic busy4;
  logic busy1;

  int n_checks;
  int n_pass;

  logic [127:0] mdl [64];
  logic [127:0] sb [$];

  pmem_responder_if bus4 ();
  pmem_responder_if bus1 ();

  pmem_responder #(.LATENCY(4), .DEPTH_LOG2(6)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .pmem  (bus4.slave),
    .busy  (busy4)
  );

  pmem_responder #(.LATENCY(1), .DEPTH_LOG2(6)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .pmem  (bus1.slave),
    .busy  (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [127:0] pat(input int i);
    return {4{32'hC0DE0000 | 32'(i)}};
  endfunction

  function automatic int line_of(input logic [15:0] addr);
    return int'(addr[9:4]);
  endfunction

  // One full transaction on the LATENCY=4 instance, request dropped in the resp cycle.
  task automatic run_txn(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [127:0] wd, input string tag);
    int k;
    bit got;
    logic [127:0] exp;
    @(posedge clk); #1;
    bus4.pmem_read    = rd;
    bus4.pmem_write   = wr;
    bus4.pmem_address = addr;
    bus4.pmem_wdata   = wd;
    if (wr) mdl[line_of(addr)] = wd;
    else    sb.push_back(mdl[line_of(addr)]);
    k   = 0;
    got = 1'b0;
    while (!got && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (bus4.pmem_resp) got = 1'b1;
    end
    bus4.pmem_read  = 1'b0;
    bus4.pmem_write = 1'b0;
    check({tag, "_lat"}, 128'(k), 128'd4);
    if (!wr) begin
      exp = sb.pop_front();
      check({tag, "_rdata"}, bus4.pmem_rdata, exp);
    end
    @(posedge clk); #1;
    check({tag, "_resp_off"}, 128'(bus4.pmem_resp), 128'd0);
    check({tag, "_busy_off"}, 128'(busy4), 128'd0);
    if (!wr) check({tag, "_rdata_held"}, bus4.pmem_rdata, exp);
  endtask

  initial begin
    logic [127:0] exp;
    logic [127:0] big;
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    bus4.pmem_read = 1'b0; bus4.pmem_write = 1'b0; bus4.pmem_address = '0; bus4.pmem_wdata = '0;
    bus1.pmem_read = 1'b0; bus1.pmem_write = 1'b0; bus1.pmem_address = '0; bus1.pmem_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp", 128'(bus4.pmem_resp), 128'd0);
    check("rst_busy", 128'(busy4), 128'd0);
    check("rst_rdata", bus4.pmem_rdata, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_txn(1'b0, 1'b1, 16'(i * 16), pat(i), "preload");

    // Plain read of line 1.
    run_txn(1'b1, 1'b0, 16'h0010, '0, "rd_line1");

    // Wide pattern, read back through an address with low nibble set.
    big = 128'h0123456789ABCDEF_FEDCBA9876543210;
    run_txn(1'b0, 1'b1, 16'h0040, big, "wr_0040");
    run_txn(1'b1, 1'b0, 16'h0047, '0, "rd_0047");

    // Read and write together behave as a write.
    run_txn(1'b1, 1'b1, 16'h0020, pat(22), "rdwr_0020");
    run_txn(1'b1, 1'b0, 16'h0020, '0, "rd_0020");

    // Abort: write to line 3 dropped in cycle 2.
    @(posedge clk); #1;
    bus4.pmem_write = 1'b1; bus4.pmem_address = 16'h0030; bus4.pmem_wdata = pat(33);
    @(posedge clk); #1;
    check("abort_busy_wait", 128'(busy4), 128'd1);
    @(posedge clk); #1;
    bus4.pmem_write = 1'b0;
    check("abort_resp_c2", 128'(bus4.pmem_resp), 128'd0);
    @(posedge clk); #1;
    check("abort_busy_off", 128'(busy4), 128'd0);
    check("abort_resp_c3", 128'(bus4.pmem_resp), 128'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_no_resp", 128'(bus4.pmem_resp), 128'd0);
    end
    run_txn(1'b1, 1'b0, 16'h0030, '0, "rd_after_abort");

    // Reset pulsed in WAIT of a write to line 5.
    @(posedge clk); #1;
    bus4.pmem_write = 1'b1; bus4.pmem_address = 16'h0058; bus4.pmem_wdata = pat(55);
    @(posedge clk); #1;
    check("rstw_busy_wait", 128'(busy4), 128'd1);
    rst_n = 1'b0;
    bus4.pmem_write = 1'b0;
    #1;
    check("rstw_resp", 128'(bus4.pmem_resp), 128'd0);
    check("rstw_busy", 128'(busy4), 128'd0);
    check("rstw_rdata", bus4.pmem_rdata, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b1, 1'b0, 16'h0058, '0, "rd_after_rst");

    // Aliasing: 0x0400 maps to line 0.
    run_txn(1'b0, 1'b1, 16'h0400, pat(400), "wr_alias");
    run_txn(1'b1, 1'b0, 16'h0000, '0, "rd_alias");

    // LATENCY=1: preload line 6, then hold read through two extra cycles.
    exp = pat(66);
    @(posedge clk); #1;
    bus1.pmem_write = 1'b1; bus1.pmem_address = 16'h0060; bus1.pmem_wdata = exp;
    @(posedge clk); #1;
    check("l1_wr_resp", 128'(bus1.pmem_resp), 128'd1);
    bus1.pmem_write = 1'b0;
    @(posedge clk); #1;
    check("l1_wr_resp_off", 128'(bus1.pmem_resp), 128'd0);
    bus1.pmem_read = 1'b1; bus1.pmem_address = 16'h0060;
    sb.push_back(exp);
    sb.push_back(exp);
    @(posedge clk); #1;
    check("l1_resp_c1", 128'(bus1.pmem_resp), 128'd1);
    check("l1_busy_c1", 128'(busy1), 128'd1);
    if (bus1.pmem_resp) check("l1_rdata_c1", bus1.pmem_rdata, sb.pop_front());
    @(posedge clk); #1;
    check("l1_resp_c2", 128'(bus1.pmem_resp), 128'd0);
    @(posedge clk); #1;
    check("l1_resp_c3", 128'(bus1.pmem_resp), 128'd1);
    if (bus1.pmem_resp) check("l1_rdata_c3", bus1.pmem_rdata, sb.pop_front());
    bus1.pmem_read = 1'b0;
    @(posedge clk); #1;
    check("l1_resp_c4", 128'(bus1.pmem_resp), 128'd0);
    check("l1_busy_c4", 128'(busy1), 128'd0);
    @(posedge clk); #1;
    check("l1_idle_c5", 128'(bus1.pmem_resp), 128'd0);

    check("sb_empty", 128'(sb.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
